egress_port_buffer: RTL and testbench
=====================================

// Module: egress_port_buffer
//
// PURPOSE
// - Per-output-port egress FIFO. Sits directly downstream of the 4-port switch
//   fabric, with one instance per output port.
// - Captures the port's valid_out / data_out / source_out beats and stores them
//   with the source port index. Presents them to an external sink over a
//   valid/ready handshake.
// - The fabric has no backpressure, so overflow and illegal-source beats are
//   dropped and counted.
// - full_o / afull_o are exported for a future arbiter throttle.
//
// PARAMETERS
// - NUM_PORTS   4   number of switch ports; width of in_source
// - DATA_WIDTH  8   payload width
// - DEPTH       4   FIFO entries; power of two, >= 2
// - AFULL_LVL   3   afull_o asserts when level >= AFULL_LVL; 1 <= AFULL_LVL <= DEPTH
// - CNT_WIDTH   8   width of the drop/error counters
//
// PORTS
// - clk          in   1                    clock; all logic on the rising edge
// - rst_n        in   1                    asynchronous, active-low reset
// - in_valid     in   1                    fabric beat valid (port valid_out)
// - in_data      in   DATA_WIDTH           fabric payload (port data_out)
// - in_source    in   NUM_PORTS            one-hot source grant (port source_out)
// - out_valid    out  1                    entry available to sink
// - out_data     out  DATA_WIDTH           head-entry payload
// - out_src_id   out  $clog2(NUM_PORTS)    binary index of the head entry's source
// - out_ready    in   1                    sink accepts the head entry
// - full_o       out  1                    level == DEPTH
// - afull_o      out  1                    level >= AFULL_LVL
// - level_o      out  $clog2(DEPTH)+1      current occupancy, 0..DEPTH
// - drop_cnt_o   out  CNT_WIDTH            overflow drops; saturating
// - err_cnt_o    out  CNT_WIDTH            illegal-source beats; saturating
//
// BEHAVIOUR
// Reset
// - rst_n low clears read/write pointers, level, both counters and all outputs
//   to 0, immediately and asynchronously.
// - Reset mid-operation discards all stored entries; there is no partial state.
//
// Legal beat, push and pop
// - Legal beat: in_valid=1 and in_source has exactly one bit set.
// - pop = out_valid & out_ready.
// - push = legal beat & (!full_o | pop). A push while full with a simultaneous
//   pop is accepted and level is unchanged.
//
// Latency and output stability
// - Latency is 1 cycle. A beat pushed at edge N gives out_valid=1 after edge N.
//   There is no same-cycle combinational bypass.
// - out_data and out_src_id are the head entry, read combinationally from
//   storage (first-word fall-through).
// - Both are 0 when out_valid=0.
// - Both must hold stable while out_valid=1 and out_ready=0.
// - Entries leave in strict arrival order.
//
// Pointers and level
// - Pointers are $clog2(DEPTH)+1 bits wide and wrap mod 2*DEPTH.
// - empty = pointers equal; full = indices equal and MSBs differ.
// - level = wr_ptr - rd_ptr, using modulo arithmetic.
// - level_o, full_o and afull_o update in the same cycle as the pointer change.
//
// Occupancy states (derived)
// - EMPTY: level 0. NORMAL: 0 < level < DEPTH. FULL: level DEPTH.
// - push only:    EMPTY->NORMAL, or NORMAL->FULL when level==DEPTH-1.
// - pop only:     FULL->NORMAL, or NORMAL->EMPTY when level==1.
// - push and pop: state is unchanged.
//
// Drops and counters
// - Overflow: a legal beat with full_o=1 and no pop is dropped and increments
//   drop_cnt_o.
// - Illegal source (in_valid=1 with in_source zero or multi-hot): the beat is
//   not stored and increments err_cnt_o, regardless of fill state.
// - Both counters saturate at all-ones and never wrap. They clear only on reset.
// - in_valid=0: no push; in_data and in_source are ignored.
// - out_ready while empty has no effect.
//
// TESTING
// 1. Reset: assert rst_n low mid-cycle -> all outputs 0 before the next edge.
//    After release, level_o=0 and out_valid=0.
// 2. Single beat: in_source=4'b0100, in_data=8'hA5, out_ready=1 -> the next
//    cycle shows out_valid=1, out_data=A5, out_src_id=2. The cycle after,
//    level_o=0 and out_valid=0.
// 3. Fill and overflow: out_ready=0, push 01,02,03,04,05 on consecutive cycles.
//    - afull_o=1 after the 3rd push; full_o=1 after the 4th push.
//    - The 5th beat (05) is dropped: drop_cnt_o=1.
//    - Then out_ready=1 -> out_data 01,02,03,04 in order, then out_valid=0.
// 4. Full with push+pop: at level 4, out_ready=1 and push 8'h10 -> accepted.
//    level_o stays 4, drop_cnt_o unchanged, and 10 arrives last.
// 5. Illegal source: in_valid=1 with in_source=4'b0011, then 4'b0000 ->
//    err_cnt_o=2 and level_o unchanged.
//    Force 300 overflows with CNT_WIDTH=8 -> drop_cnt_o=255.
// 6. Reset mid-drain: level 3, out_valid=1, pull rst_n low -> out_valid=0 and
//    level_o=0 asynchronously. After release, no stale data appears.

Source files
------------

// File: rtl/egress_port_buffer.sv
// rtl/egress_port_buffer.sv - per-output-port egress FIFO with drop/error counters
module egress_port_buffer #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int AFULL_LVL  = 3,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic [NUM_PORTS-1:0]         in_source,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [$clog2(NUM_PORTS)-1:0] out_src_id,
  input  logic                         out_ready,
  output logic                         full_o,
  output logic                         afull_o,
  output logic [$clog2(DEPTH):0]       level_o,
  output logic [CNT_WIDTH-1:0]         drop_cnt_o,
  output logic [CNT_WIDTH-1:0]         err_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(NUM_PORTS);

  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [SW-1:0]         src_mem  [DEPTH];

  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  drop_cnt_q, drop_cnt_d;
  logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;

  logic                  empty, full, onehot, legal, push, pop, overflow, illegal;
  logic [SW-1:0]         src_idx;
  logic [AW:0]           level;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign level  = wr_ptr_q - rd_ptr_q;

  assign onehot   = (in_source != '0) && ((in_source & (in_source - 1'b1)) == '0);
  assign legal    = in_valid && onehot;
  assign illegal  = in_valid && !onehot;
  assign pop      = out_valid && out_ready;
  assign push     = legal && (!full || pop);
  assign overflow = legal && full && !pop;

  always_comb begin
    src_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (in_source[i]) src_idx = SW'(i);
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
    drop_cnt_d = drop_cnt_q;
    err_cnt_d  = err_cnt_q;
    // Counters stick at all-ones rather than wrapping.
    if (overflow && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
    if (illegal && (err_cnt_q != '1))   err_cnt_d  = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      drop_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      drop_cnt_q <= drop_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q[AW-1:0]] <= in_data;
      src_mem[wr_ptr_q[AW-1:0]]  <= src_idx;
    end
  end

  // Head entry falls through combinationally; gated to zero when empty.
  assign out_valid  = !empty;
  assign out_data   = out_valid ? data_mem[rd_ptr_q[AW-1:0]] : '0;
  assign out_src_id = out_valid ? src_mem[rd_ptr_q[AW-1:0]]  : '0;

  assign full_o     = full;
  assign afull_o    = (level >= (AW+1)'(AFULL_LVL));
  assign level_o    = level;
  assign drop_cnt_o = drop_cnt_q;
  assign err_cnt_o  = err_cnt_q;

endmodule

// File: tb/tb_egress_port_buffer.sv
// tb/tb_egress_port_buffer.sv - directed self-checking bench for egress_port_buffer
module tb_egress_port_buffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic [3:0] in_source;
  logic       out_valid;
  logic [7:0] out_data;
  logic [1:0] out_src_id;
  logic       out_ready;
  logic       full_o;
  logic       afull_o;
  logic [2:0] level_o;
  logic [7:0] drop_cnt_o;
  logic [7:0] err_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  egress_port_buffer #(
    .NUM_PORTS(4), .DATA_WIDTH(8), .DEPTH(4), .AFULL_LVL(3), .CNT_WIDTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_source(in_source),
    .out_valid(out_valid), .out_data(out_data), .out_src_id(out_src_id),
    .out_ready(out_ready),
    .full_o(full_o), .afull_o(afull_o), .level_o(level_o),
    .drop_cnt_o(drop_cnt_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives one beat, clocks it in, returns at the next negedge.
  task automatic beat(input logic v, input logic [7:0] d, input logic [3:0] s, input logic rdy);
    in_valid  = v;
    in_data   = d;
    in_source = s;
    out_ready = rdy;
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"},  out_data,  0);
    check({tag, "_src"},   out_src_id, 0);
    check({tag, "_level"}, level_o,   0);
    check({tag, "_full"},  full_o,    0);
    check({tag, "_afull"}, afull_o,   0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_source = 4'h0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("rst");
    check("rst_drop", drop_cnt_o, 0);
    check("rst_err",  err_cnt_o,  0);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("rel");

    // Single beat, one-cycle latency, then drained.
    in_valid = 1'b1; in_data = 8'hA5; in_source = 4'b0100; out_ready = 1'b1;
    #1;
    check("t2_nobypass", out_valid, 0);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check("t2_valid", out_valid, 1);
    check("t2_data",  out_data,  8'hA5);
    check("t2_src",   out_src_id, 2);
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    check_idle("t2_after");

    // Fill with out_ready low; fifth beat overflows.
    for (int i = 1; i <= 5; i++) begin
      beat(1'b1, 8'(i), 4'(1 << (i % 4)), 1'b0);
      check($sformatf("t3_level%0d", i), level_o, (i > 4) ? 4 : i);
      check($sformatf("t3_afull%0d", i), afull_o, (i >= 3) ? 1 : 0);
      check($sformatf("t3_full%0d", i),  full_o,  (i >= 4) ? 1 : 0);
    end
    check("t3_drop", drop_cnt_o, 1);
    check("t3_err",  err_cnt_o,  0);
    out_ready = 1'b1;
    #1;
    check("t3_hold_data", out_data, 8'h01);
    for (int j = 1; j <= 4; j++) begin
      check($sformatf("t3_data%0d", j), out_data, j);
      check($sformatf("t3_src%0d", j),  out_src_id, j % 4);
      beat(1'b0, 8'hEE, 4'hF, 1'b1);
    end
    check_idle("t3_end");

    // Push and pop together while full: level stays at 4, no drop.
    for (int i = 0; i < 4; i++) beat(1'b1, 8'h20 + 8'(i), 4'b0001, 1'b0);
    check("t4_full", full_o, 1);
    beat(1'b1, 8'h10, 4'b1000, 1'b1);
    check("t4_level", level_o, 4);
    check("t4_full2", full_o, 1);
    check("t4_drop",  drop_cnt_o, 1);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("t4_data%0d", j), out_data, (j == 3) ? 8'h10 : 8'h21 + j);
      check($sformatf("t4_src%0d", j),  out_src_id, (j == 3) ? 3 : 0);
      beat(1'b0, 8'h00, 4'h0, 1'b1);
    end
    check_idle("t4_end");

    // Illegal sources are counted and not stored; in_valid=0 ignores the source.
    beat(1'b1, 8'h33, 4'b0011, 1'b0);
    beat(1'b1, 8'h44, 4'b0000, 1'b0);
    beat(1'b0, 8'h55, 4'b1111, 1'b0);
    check("t5_err",   err_cnt_o, 2);
    check("t5_level", level_o,   0);
    check("t5_valid", out_valid, 0);

    // Overflow 300 times: counter saturates at 255 (1 earlier drop + 300).
    for (int i = 0; i < 4; i++) beat(1'b1, 8'h60 + 8'(i), 4'b0010, 1'b0);
    for (int i = 0; i < 300; i++) beat(1'b1, 8'hFF, 4'b0100, 1'b0);
    check("t5_sat",     drop_cnt_o, 255);
    check("t5_satlvl",  level_o,    4);
    check("t5_sathead", out_data,   8'h60);
    beat(1'b1, 8'h00, 4'b0101, 1'b0);
    check("t5_err_full", err_cnt_o, 3);
    check("t5_drop_hold", drop_cnt_o, 255);

    // Drain one to reach level 3, then reset asynchronously mid-cycle.
    beat(1'b0, 8'h00, 4'h0, 1'b1);
    check("t6_level3", level_o, 3);
    check("t6_valid",  out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("t6_async");
    check("t6_drop", drop_cnt_o, 0);
    check("t6_err",  err_cnt_o,  0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    check_idle("t6_rel");
    beat(1'b1, 8'h77, 4'b1000, 1'b0);
    check("t6_new_level", level_o, 1);
    check("t6_new_data",  out_data, 8'h77);
    check("t6_new_src",   out_src_id, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
